// File: rtl/text_mode_pkg.sv
// Shared constants, control codes and state encoding for the text-mode screen path.
package text_mode_pkg;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 25;
    localparam int unsigned COL_BITS = 7;
    localparam int unsigned ROW_BITS = 5;

    localparam logic [7:0] FILL_CHAR   = 8'h20;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        CLEAR
    } arb_state_t;

    // Printable ASCII range that the writer stores into screen RAM.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Column/row position register with terminal-style advance, CR, LF, BS and home commands.
// Commands are mutually prioritised: home > advance > cr > lf > bs.
module text_cursor #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 25,
    parameter int unsigned COL_BITS = 7,
    parameter int unsigned ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                home,
    input  logic                advance,
    input  logic                cr,
    input  logic                lf,
    input  logic                bs,
    output logic [COL_BITS-1:0] x,
    output logic [ROW_BITS-1:0] y,
    output logic                at_last
);

    localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(ROWS - 1);

    logic [ROW_BITS-1:0] y_next_row;

    // Row increment shared by advance and LF; the last row wraps to 0 (no scrolling).
    always_comb begin
        y_next_row = (y == Y_MAX) ? '0 : y + ROW_BITS'(1);
    end

    assign at_last = (x == X_MAX) && (y == Y_MAX);

    // Position update for the highest-priority command asserted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (home) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= y_next_row;
            end else begin
                x <= x + COL_BITS'(1);
            end
        end else if (cr) begin
            x <= '0;
        end else if (lf) begin
            y <= y_next_row;
        end else if (bs) begin
            if (x != '0) begin
                x <= x - COL_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/screen_ram_arbiter.sv
// Owner of the single-port screen RAM: video fetch reads take absolute priority,
// a terminal-style character writer and a full-screen clear sequencer use idle cycles.
module screen_ram_arbiter
    import text_mode_pkg::*;
#(
    parameter int unsigned COLS      = text_mode_pkg::COLS,
    parameter int unsigned ROWS      = text_mode_pkg::ROWS,
    parameter int unsigned COL_BITS  = text_mode_pkg::COL_BITS,
    parameter int unsigned ROW_BITS  = text_mode_pkg::ROW_BITS,
    parameter logic [7:0]  FILL_CHAR = text_mode_pkg::FILL_CHAR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vid_req,
    input  logic [ROW_BITS+COL_BITS-1:0] vid_addr,
    output logic                         vid_valid,
    output logic [7:0]                   vid_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [7:0]                   wr_char,
    input  logic                         clr_req,
    output logic                         busy,
    output logic [COL_BITS-1:0]          cursor_x,
    output logic [ROW_BITS-1:0]          cursor_y,
    output logic [ROW_BITS+COL_BITS-1:0] ram_address,
    output logic [7:0]                   ram_data,
    output logic                         ram_wren,
    input  logic [7:0]                   ram_q
);

    arb_state_t          state;
    logic [7:0]          pend_char;
    logic [COL_BITS-1:0] clr_x;
    logic [ROW_BITS-1:0] clr_y;
    logic                clr_last;
    logic                cur_last;

    logic accept;
    logic start_clear;
    logic pend_write;
    logic clr_write;
    logic clr_done;

    assign wr_ready    = ~rst && (state == IDLE) && ~clr_req;
    assign accept      = wr_valid && wr_ready;
    assign start_clear = (state == IDLE) && clr_req;
    assign pend_write  = (state == PEND) && ~vid_req;
    assign clr_write   = (state == CLEAR) && ~vid_req;
    assign clr_done    = clr_write && clr_last;
    assign busy        = (state != IDLE);
    assign vid_data    = ram_q;

    text_cursor #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .COL_BITS(COL_BITS),
        .ROW_BITS(ROW_BITS)
    ) u_cursor (
        .clk    (clk),
        .rst    (rst),
        .home   (clr_done),
        .advance(pend_write),
        .cr     (accept && (wr_char == CH_CR)),
        .lf     (accept && (wr_char == CH_LF)),
        .bs     (accept && (wr_char == CH_BS)),
        .x      (cursor_x),
        .y      (cursor_y),
        .at_last(cur_last)
    );

    // The clear sweep walks the screen with the same advance rule as the cursor;
    // its final advance wraps back to (0,0) on its own.
    text_cursor #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .COL_BITS(COL_BITS),
        .ROW_BITS(ROW_BITS)
    ) u_clear_ctr (
        .clk    (clk),
        .rst    (rst),
        .home   (start_clear),
        .advance(clr_write),
        .cr     (1'b0),
        .lf     (1'b0),
        .bs     (1'b0),
        .x      (clr_x),
        .y      (clr_y),
        .at_last(clr_last)
    );

    // Writer / clear sequencer state; control codes complete in IDLE without a RAM cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_char <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                    end else if (accept && is_printable(wr_char)) begin
                        pend_char <= wr_char;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (!vid_req) begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Video read data returns a fixed one cycle after the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_req;
        end
    end

    // RAM port mux: video first, then the pending character, then the clear sweep.
    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (vid_req) begin
            ram_address = vid_addr;
        end else if (state == PEND) begin
            ram_address = {cursor_y, cursor_x};
            ram_data    = pend_char;
            ram_wren    = 1'b1;
        end else if (state == CLEAR) begin
            ram_address = {clr_y, clr_x};
            ram_data    = FILL_CHAR;
            ram_wren    = 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = cur_last;

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Directed bench for screen_ram_arbiter with a behavioural screen RAM and
// scoreboards for expected RAM writes and expected video read data.
module tb_screen_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_char;
    logic        clr_req;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q;

    logic [7:0]  mem [4096];
    logic [19:0] exp_wr[$];
    logic [7:0]  exp_vid[$];
    logic        vid_req_d;
    logic [19:0] e;
    int          total = 0;
    int          bad   = 0;
    int          wr_seen = 0;

    screen_ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_valid  (vid_valid),
        .vid_data   (vid_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .clr_req    (clr_req),
        .busy       (busy),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Single-port RAM with one-cycle read latency (read-before-write).
    always @(posedge clk) begin
        ram_q <= mem[ram_address];
        if (ram_wren) mem[ram_address] = ram_data;
    end

    // Reference delay of the video request.
    always @(posedge clk or posedge rst) begin
        if (rst) vid_req_d <= 1'b0;
        else     vid_req_d <= vid_req;
    end

    // Output monitor: every RAM write and every video return is matched to the scoreboards.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            wr_seen++;
            chk("wren_under_vid", 32'(vid_req), 32'd0);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(ram_address), 32'(e[19:8]));
                chk("wr_data", 32'(ram_data), 32'(e[7:0]));
            end else begin
                chk("wr_spurious", 32'(ram_wren), 32'd0);
            end
        end
        chk("vid_valid", 32'(vid_valid), 32'(vid_req_d));
        if (vid_valid === 1'b1) begin
            if (exp_vid.size() > 0) chk("vid_data", 32'(vid_data), 32'(exp_vid.pop_front()));
            else                    chk("vid_spurious", 32'(vid_valid), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] ch);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_char  = ch;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic push_clear();
        for (int unsigned y = 0; y < 25; y++)
            for (int unsigned x = 0; x < 80; x++)
                exp_wr.push_back({5'(y), 7'(x), 8'h20});
    endtask

    initial begin
        int n;
        int base;
        logic seen_ready;
        for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        wr_valid = 1'b0; wr_char = '0; clr_req = 1'b0;
        #2;
        // reset state
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", {20'd0, cursor_y, cursor_x}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 'A' at (0,0)
        exp_wr.push_back({12'h000, 8'h41});
        send(8'h41);
        wait_idle();
        chk("a_cursor_x", 32'(cursor_x), 32'd1);
        chk("a_cursor_y", 32'(cursor_y), 32'd0);

        // 2: reach (79,3), then 'Z' wraps to next row
        for (int i = 0; i < 3; i++) send(8'h0A);
        chk("lf3_y", 32'(cursor_y), 32'd3);
        for (int unsigned x = 1; x < 79; x++) begin
            exp_wr.push_back({5'd3, 7'(x), 8'h61});
            send(8'h61);
            wait_idle();
        end
        chk("pre_z_x", 32'(cursor_x), 32'd79);
        exp_wr.push_back({12'h1CF, 8'h5A});
        send(8'h5A);
        wait_idle();
        chk("z_cursor_x", 32'(cursor_x), 32'd0);
        chk("z_cursor_y", 32'(cursor_y), 32'd4);
        for (int i = 0; i < 20; i++) send(8'h0A);
        chk("lf_y24", 32'(cursor_y), 32'd24);
        send(8'h0A);
        chk("lf_wrap_y", 32'(cursor_y), 32'd0);

        // 3: video holds off a pending write for 10 clocks
        vid_req  = 1'b1;
        vid_addr = {5'd0, 7'd100};
        exp_vid.push_back(pat(vid_addr));
        exp_wr.push_back({12'h000, 8'h51});
        send(8'h51);
        for (int i = 1; i < 10; i++) begin
            vid_addr = {5'(i), 7'(100 + i)};
            exp_vid.push_back(pat(vid_addr));
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_wren", 32'(ram_wren), 32'd0);
            @(posedge clk); #1;
        end
        vid_req = 1'b0;
        #1;
        chk("release_wren", 32'(ram_wren), 32'd1);
        chk("release_addr", 32'(ram_address), 32'h000);
        @(posedge clk); #1;
        chk("release_idle", 32'(busy), 32'd0);
        chk("q_cursor_x", 32'(cursor_x), 32'd1);
        @(posedge clk); #1;
        chk("vid_drained", 32'(exp_vid.size()), 32'd0);

        // 4: CR, BS at x=0, dropped code
        send(8'h0D);
        chk("cr_x", 32'(cursor_x), 32'd0);
        chk("cr_idle", 32'(busy), 32'd0);
        send(8'h08);
        chk("bs_x0", 32'(cursor_x), 32'd0);
        send(8'h07);
        chk("bel_cursor", {20'd0, cursor_y, cursor_x}, 32'd0);
        chk("bel_ready", 32'(wr_ready), 32'd1);
        chk("bel_idle", 32'(busy), 32'd0);

        // 5: full clear
        send(8'h0A);
        push_clear();
        clr_req = 1'b1;
        #1;
        chk("clr_ready_lo", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        clr_req = 1'b0;
        n = 0;
        seen_ready = 1'b0;
        while (busy === 1'b1 && n < 3000) begin
            if (wr_ready !== 1'b0) seen_ready = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        chk("clr_busy_cycles", 32'(n), 32'd2000);
        chk("clr_ready_during", 32'(seen_ready), 32'd0);
        chk("clr_all_written", 32'(exp_wr.size()), 32'd0);
        chk("clr_cursor", {20'd0, cursor_y, cursor_x}, 32'd0);

        // 6: reset in the middle of a clear
        push_clear();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        base = wr_seen;
        n = 0;
        while (wr_seen - base < 500 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_progress", 32'(wr_seen - base), 32'd500);
        rst = 1'b1;
        #1;
        chk("abort_wren", 32'(ram_wren), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cursor", {20'd0, cursor_y, cursor_x}, 32'd0);
        chk("abort_left", 32'(exp_wr.size()), 32'd1500);
        exp_wr.delete();
        base = wr_seen;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
        end
        chk("post_rst_writes", 32'(wr_seen - base), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(wr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
